// File: rtl/multi_desel.sv
// -----------------------------------------------------------------------------
// multi_desel
//
// Receive-side checker for the x1/x3/x7/x8 serial product stream of the
// shift-multiply selector. A group is four consecutive words: x1, x3, x7, x8.
// The x1 word is marked by in_grant. The checker recovers the 8-bit operand
// from the x1 word. It then compares the next three words against locally
// computed shift/add products. For every completed group it reports the
// operand and a pass/fail flag.
//
// Stream handshake: the input stream has no backpressure. Every rising edge
// consumes exactly one word, and in_grant is only a framing mark. d_valid and
// sync_err are one-cycle strobes with no ready. A consumer must take d_out and
// d_err in the cycle where d_valid is high.
//
// Ports
//   clk        in   1          system clock, rising-edge state updates
//   rst        in   1          asynchronous active-low reset
//   in_grant   in   1          high on the cycle carrying the x1 word
//   in_data    in   11         product word (x1, x3, x7, x8 in sequence)
//   d_out      out  8          recovered operand, held until next completion
//   d_valid    out  1          one-cycle pulse when a group completes
//   d_err      out  1          group mismatch flag, qualified by d_valid
//   sync_err   out  1          one-cycle pulse on a framing error
//   err_cnt    out  ERR_CNT_W  saturating count of bad groups + framing errors
//   dbg_state  out  2          current FSM state (IDLE=0, P1=1, P2=2, P3=3)
// -----------------------------------------------------------------------------
module multi_desel #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_grant,
  input  logic [10:0]          in_data,
  output logic [7:0]           d_out,
  output logic                 d_valid,
  output logic                 d_err,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  // IDLE: waiting for an x1 word. P1/P2/P3: expecting the x3/x7/x8 word.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    P3   = 2'd3
  } state_e;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [7:0]           base_q, base_d;
  logic                 mismatch_q, mismatch_d;
  logic [7:0]           d_out_q, d_out_d;
  logic                 d_valid_q, d_valid_d;
  logic                 d_err_q, d_err_d;
  logic                 sync_err_q, sync_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Reference products, all at 11 bits. 255*8 = 2040 fits, so none of them
  // wraps. The x7 term is formed as x8 - x1, the same way the sender builds it.
  logic [10:0] prod_x1;
  logic [10:0] prod_x2;
  logic [10:0] prod_x3;
  logic [10:0] prod_x8;
  logic [10:0] prod_x7;

  assign prod_x1 = {3'b000, base_q};
  assign prod_x2 = {2'b00, base_q, 1'b0};
  assign prod_x3 = prod_x2 + prod_x1;
  assign prod_x8 = {base_q, 3'b000};
  assign prod_x7 = prod_x8 - prod_x1;

  // Mismatch verdicts for the word currently on in_data, one per position.
  logic miss_x3;
  logic miss_x7;
  logic miss_x8;

  assign miss_x3 = (in_data != prod_x3);
  assign miss_x7 = (in_data != prod_x7);
  assign miss_x8 = (in_data != prod_x8);

  // Single increment request per edge. A framing error and a group completion
  // cannot occur on the same edge, because completion needs in_grant low.
  logic err_inc;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mismatch_d = mismatch_q;
    d_out_d    = d_out_q;
    d_valid_d  = 1'b0;
    d_err_d    = 1'b0;
    sync_err_d = 1'b0;
    err_inc    = 1'b0;

    if (in_grant) begin
      // A grant outside IDLE means the previous group was cut short. That
      // group is dropped silently. The error is carried by sync_err and
      // err_cnt, and this word restarts framing as a fresh x1 word.
      if (state_q != IDLE) begin
        sync_err_d = 1'b1;
        err_inc    = 1'b1;
      end
      base_d     = in_data[7:0];
      // An x1 word of an 8-bit operand must have clear upper bits.
      mismatch_d = (in_data[10:8] != 3'b000);
      state_d    = P1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        P1: begin
          mismatch_d = mismatch_q | miss_x3;
          state_d    = P2;
        end
        P2: begin
          mismatch_d = mismatch_q | miss_x7;
          state_d    = P3;
        end
        P3: begin
          d_out_d    = base_q;
          d_valid_d  = 1'b1;
          d_err_d    = mismatch_q | miss_x8;
          err_inc    = mismatch_q | miss_x8;
          mismatch_d = 1'b0;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Saturating error counter. It holds at all-ones and never wraps.
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= 8'd0;
      mismatch_q <= 1'b0;
      d_out_q    <= 8'd0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mismatch_q <= mismatch_d;
      d_out_q    <= d_out_d;
      d_valid_q  <= d_valid_d;
      d_err_q    <= d_err_d;
      sync_err_q <= sync_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign d_out     = d_out_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign sync_err  = sync_err_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multi_desel.sv
// -----------------------------------------------------------------------------
// tb_multi_desel
//
// Directed bench for multi_desel. Two instances share one input stream: the
// default 8-bit counter and a 2-bit counter that exercises saturation.
// Expected group and framing events are queued as the causing word is driven.
// A monitor pops one entry per output event, on the falling edge.
// -----------------------------------------------------------------------------
module tb_multi_desel;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_grant = 1'b0;
  logic [10:0] in_data = 11'd0;

  logic [7:0]  d_out,    d_out2;
  logic        d_valid,  d_valid2;
  logic        d_err,    d_err2;
  logic        sync_err, sync_err2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;
  logic [1:0]  dbg_state, dbg_state2;

  always #5 clk = ~clk;

  multi_desel #(.ERR_CNT_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_grant  (in_grant),
    .in_data   (in_data),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .d_err     (d_err),
    .sync_err  (sync_err),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  multi_desel #(.ERR_CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_grant  (in_grant),
    .in_data   (in_data),
    .d_out     (d_out2),
    .d_valid   (d_valid2),
    .d_err     (d_err2),
    .sync_err  (sync_err2),
    .err_cnt   (err_cnt2),
    .dbg_state (dbg_state2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // Entry layout: {is_sync, d_out[7:0], d_err, err_cnt[7:0], err_cnt2[1:0]}
  // ---------------------------------------------------------------------------
  localparam int EXP_W = 20;
  logic [EXP_W-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_dout = 8'd0;
  logic [7:0] exp_cnt8 = 8'd0;
  logic [1:0] exp_cnt2 = 2'd0;

  task automatic check(input string name, input logic [10:0] act,
                       input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-derived bookkeeping for the counters. The 2-bit instance holds at 3.
  task automatic bump_counts();
    exp_cnt8 = exp_cnt8 + 8'd1;
    if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
  endtask

  task automatic push_valid(input logic [7:0] d, input logic err);
    if (err) bump_counts();
    exp_dout = d;
    exp_q.push_back({1'b0, d, err, exp_cnt8, exp_cnt2});
  endtask

  task automatic push_sync();
    bump_counts();
    exp_q.push_back({1'b1, exp_dout, 1'b0, exp_cnt8, exp_cnt2});
  endtask

  // ---------------------------------------------------------------------------
  // Driver: present one word, let one rising edge consume it
  // ---------------------------------------------------------------------------
  task automatic word(input logic g, input logic [10:0] d);
    in_grant = g;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) word(1'b0, 11'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one queue entry per d_valid or sync_err pulse
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst && (d_valid || sync_err || d_valid2 || sync_err2)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got valid=%0d sync=%0d, expected none (t=%0t)",
                 d_valid, sync_err, $time);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("event_is_sync",  {10'd0, sync_err && !d_valid}, {10'd0, e[19]});
        check("d_out",          {3'd0, d_out},                  {3'd0, e[18:11]});
        check("d_err",          {10'd0, d_err},                 {10'd0, e[10]});
        check("err_cnt",        {3'd0, err_cnt},                {3'd0, e[9:2]});
        check("err_cnt_w2",     {9'd0, err_cnt2},               {9'd0, e[1:0]});
        check("w2_same_event",  {9'd0, d_valid2, sync_err2},    {9'd0, d_valid, sync_err});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state, sampled while rst is held low.
    #2;
    check("rst_d_out",    {3'd0, d_out},     11'd0);
    check("rst_d_valid",  {10'd0, d_valid},  11'd0);
    check("rst_d_err",    {10'd0, d_err},    11'd0);
    check("rst_sync_err", {10'd0, sync_err}, 11'd0);
    check("rst_err_cnt",  {3'd0, err_cnt},   11'd0);
    check("rst_state",    {9'd0, dbg_state}, 11'd0);
    #5 rst = 1'b1;
    @(posedge clk);
    #1;

    // Operand 5, clean group.
    word(1'b1, 11'd5);  word(1'b0, 11'd15); word(1'b0, 11'd35);
    push_valid(8'd5, 1'b0);
    word(1'b0, 11'd40);
    idle_gap();

    // Operand 255, then operand 1 back-to-back.
    word(1'b1, 11'd255); word(1'b0, 11'd765); word(1'b0, 11'd1785);
    push_valid(8'd255, 1'b0);
    word(1'b0, 11'd2040);
    word(1'b1, 11'd1);   word(1'b0, 11'd3);   word(1'b0, 11'd7);
    push_valid(8'd1, 1'b0);
    word(1'b0, 11'd8);
    idle_gap();

    // Corrupted x7 word.
    word(1'b1, 11'd10); word(1'b0, 11'd30); word(1'b0, 11'd71);
    push_valid(8'd10, 1'b1);
    word(1'b0, 11'd80);
    idle_gap();

    // Framing error: group for 3 cut short by a new grant carrying 4.
    word(1'b1, 11'd3); word(1'b0, 11'd9);
    push_sync();
    word(1'b1, 11'd4); word(1'b0, 11'd12); word(1'b0, 11'd28);
    push_valid(8'd4, 1'b0);
    word(1'b0, 11'd32);
    idle_gap();

    // x1 word with non-zero upper bits.
    word(1'b1, 11'h105); word(1'b0, 11'd15); word(1'b0, 11'd35);
    push_valid(8'd5, 1'b1);
    word(1'b0, 11'd40);
    idle_gap();

    // Reset while in P2: outputs clear at once, and the rest of the group
    // must not complete.
    word(1'b1, 11'd6); word(1'b0, 11'd18);
    check("pre_rst_state", {9'd0, dbg_state}, 11'd2);
    rst = 1'b0;
    #1;
    check("midrst_d_out",   {3'd0, d_out},      11'd0);
    check("midrst_err_cnt", {3'd0, err_cnt},    11'd0);
    check("midrst_cnt_w2",  {9'd0, err_cnt2},   11'd0);
    check("midrst_state",   {9'd0, dbg_state},  11'd0);
    check("midrst_d_valid", {10'd0, d_valid},   11'd0);
    exp_dout = 8'd0;
    exp_cnt8 = 8'd0;
    exp_cnt2 = 2'd0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    word(1'b0, 11'd42); word(1'b0, 11'd48); word(1'b0, 11'd0);

    // Four errored groups: 8-bit counter reaches 4, 2-bit counter holds at 3.
    for (int g = 0; g < 4; g++) begin
      word(1'b1, 11'd10); word(1'b0, 11'd30); word(1'b0, 11'd71);
      push_valid(8'd10, 1'b1);
      word(1'b0, 11'd80);
    end

    // Drain; every queued event must have been observed.
    repeat (4) word(1'b0, 11'd0);
    check("exp_q_drained", 11'(exp_q.size()), 11'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
